// File: rtl/cpipe2_stage_reg.sv
// Stage-1 -> stage-2 control pipeline register with one-entry skid buffer,
// flush handling and post-return NOP (nil-slot) injection.
module cpipe2_stage_reg #(
    parameter int unsigned     W         = 8,
    parameter logic [W-1:0]    NOP_CODE  = W'(8'hB8),
    parameter int unsigned     NIL_SLOTS = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         c1_valid,
    input  logic [W-1:0] c1_word,
    output logic         c1_ready,
    input  logic         stall2,
    input  logic         flush,
    input  logic         nill_on_return,
    output logic [W-1:0] CPIPE2s,
    output logic         cpipe2_valid,
    output logic         nill_active
);

    localparam int unsigned CW = 4;

    typedef enum logic {RUN, NILL} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   word_q, word_d;
    logic           valid_q, valid_d;
    logic [W-1:0]   skid_q, skid_d;
    logic           skid_full_q, skid_full_d;
    logic           accept;
    logic           ret_hit;

    assign c1_ready     = !skid_full_q && !reset;
    assign accept       = c1_valid && c1_ready;
    assign ret_hit      = (state_q == RUN) && valid_q && nill_on_return && (NIL_SLOTS != 0);
    assign CPIPE2s      = word_q;
    assign cpipe2_valid = valid_q;
    assign nill_active  = (state_q == NILL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            word_q      <= NOP_CODE;
            valid_q     <= 1'b0;
            skid_q      <= '0;
            skid_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            word_q      <= word_d;
            valid_q     <= valid_d;
            skid_q      <= skid_d;
            skid_full_q <= skid_full_d;
        end
    end

    // Priority per edge: flush > stall2 > NOP injection > normal advance.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        word_d      = word_q;
        valid_d     = valid_q;
        skid_d      = skid_q;
        skid_full_d = skid_full_q;

        if (flush) begin
            state_d     = RUN;
            cnt_d       = '0;
            word_d      = NOP_CODE;
            valid_d     = 1'b0;
            skid_full_d = 1'b0;
        end else if (stall2) begin
            if (accept) begin
                skid_d      = c1_word;
                skid_full_d = 1'b1;
            end
        end else if (ret_hit || (state_q == NILL && cnt_q != '0)) begin
            // Squash slot: emit a NOP, park any accepted word in the skid.
            word_d  = NOP_CODE;
            valid_d = 1'b0;
            if (ret_hit) begin
                state_d = NILL;
                cnt_d   = CW'(NIL_SLOTS - 1);
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
            if (accept) begin
                skid_d      = c1_word;
                skid_full_d = 1'b1;
            end
        end else begin
            state_d = RUN;
            if (skid_full_q) begin
                word_d      = skid_q;
                valid_d     = 1'b1;
                skid_full_d = accept;
                if (accept) begin
                    skid_d = c1_word;
                end
            end else if (accept) begin
                word_d  = c1_word;
                valid_d = 1'b1;
            end else begin
                word_d  = NOP_CODE;
                valid_d = 1'b0;
            end
        end
    end

endmodule
